// File: rtl/aq_apb_pkg.sv
// Shared definitions for the APB master bridge: FSM state encoding and
// fixed APB data/strobe widths.

package aq_apb_pkg;

   localparam int APB_DATA_W = 32;
   localparam int APB_STRB_W = APB_DATA_W / 8;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      WAIT   = 3'd1,
      SETUP  = 3'd2,
      ACCESS = 3'd3,
      RESP   = 3'd4
   } apb_state_e;

endpackage

// File: rtl/aq_apb_mst_bridge_if.sv
// CPU request/response handshake and APB4 bus seen by the APB master bridge.
// The master modport is the bridge's view, slave is the surrounding system.

interface aq_apb_mst_bridge_if #(
   parameter int ADDR_W = 32
) ();
   import aq_apb_pkg::*;

   logic                  req_vld;
   logic                  req_rdy;
   logic                  req_write;
   logic [ADDR_W-1:0]     req_addr;
   logic [APB_DATA_W-1:0] req_wdata;
   logic [APB_STRB_W-1:0] req_strb;

   logic                  rsp_vld;
   logic                  rsp_rdy;
   logic [APB_DATA_W-1:0] rsp_rdata;
   logic                  rsp_err;

   logic                  psel;
   logic                  penable;
   logic                  pwrite;
   logic [ADDR_W-1:0]     paddr;
   logic [APB_DATA_W-1:0] pwdata;
   logic [APB_STRB_W-1:0] pstrb;
   logic [APB_DATA_W-1:0] prdata;
   logic                  pready;
   logic                  pslverr;

   modport master (
      input  req_vld, req_write, req_addr, req_wdata, req_strb,
      output req_rdy,
      output rsp_vld, rsp_rdata, rsp_err,
      input  rsp_rdy,
      output psel, penable, pwrite, paddr, pwdata, pstrb,
      input  prdata, pready, pslverr
   );

   modport slave (
      output req_vld, req_write, req_addr, req_wdata, req_strb,
      input  req_rdy,
      input  rsp_vld, rsp_rdata, rsp_err,
      output rsp_rdy,
      input  psel, penable, pwrite, paddr, pwdata, pstrb,
      output prdata, pready, pslverr
   );

endinterface

// File: rtl/aq_apb_mst_bridge.sv
// APB4 master bridge: one outstanding CPU request turned into an APB transfer,
// phases advanced only on apb_clk_en strobes, with a slave-hang timeout.
//
// state  | meaning
// IDLE   | ready for a CPU request (req_rdy=1)
// WAIT   | request latched, psel raised on the next strobe
// SETUP  | APB setup phase, penable raised on the next strobe
// ACCESS | APB access phase, waiting for pready or timeout
// RESP   | response held until rsp_rdy

module aq_apb_mst_bridge
   import aq_apb_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 256
) (
   input  logic                forever_cpuclk,
   input  logic                cpurst_b,
   input  logic                apb_clk_en,
   aq_apb_mst_bridge_if.master bus
);

   localparam int               CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   apb_state_e            state_q, state_d;

   logic                  lat_write_q, lat_write_d;
   logic [ADDR_W-1:0]     lat_addr_q, lat_addr_d;
   logic [APB_DATA_W-1:0] lat_wdata_q, lat_wdata_d;
   logic [APB_STRB_W-1:0] lat_strb_q, lat_strb_d;

   logic                  psel_q, psel_d;
   logic                  penable_q, penable_d;
   logic                  pwrite_q, pwrite_d;
   logic [ADDR_W-1:0]     paddr_q, paddr_d;
   logic [APB_DATA_W-1:0] pwdata_q, pwdata_d;
   logic [APB_STRB_W-1:0] pstrb_q, pstrb_d;

   logic [APB_DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic                  rsp_err_q, rsp_err_d;

   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  tout_hit;

   assign tout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

   always_ff @(posedge forever_cpuclk) begin
      if (!cpurst_b) begin
         state_q     <= IDLE;
         lat_write_q <= 1'b0;
         lat_addr_q  <= '0;
         lat_wdata_q <= '0;
         lat_strb_q  <= '0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         pstrb_q     <= '0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         lat_write_q <= lat_write_d;
         lat_addr_q  <= lat_addr_d;
         lat_wdata_q <= lat_wdata_d;
         lat_strb_q  <= lat_strb_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         pwrite_q    <= pwrite_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         pstrb_q     <= pstrb_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         cnt_q       <= cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      lat_write_d = lat_write_q;
      lat_addr_d  = lat_addr_q;
      lat_wdata_d = lat_wdata_q;
      lat_strb_d  = lat_strb_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      pwrite_d    = pwrite_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      pstrb_d     = pstrb_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      cnt_d       = cnt_q;

      case (state_q)
         IDLE: begin
            if (bus.req_vld) begin
               lat_write_d = bus.req_write;
               lat_addr_d  = bus.req_addr;
               lat_wdata_d = bus.req_wdata;
               lat_strb_d  = bus.req_write ? bus.req_strb : '0;
               state_d     = WAIT;
            end
         end
         WAIT: begin
            if (apb_clk_en) begin
               psel_d    = 1'b1;
               penable_d = 1'b0;
               pwrite_d  = lat_write_q;
               paddr_d   = lat_addr_q;
               pwdata_d  = lat_wdata_q;
               pstrb_d   = lat_strb_q;
               state_d   = SETUP;
            end
         end
         SETUP: begin
            if (apb_clk_en) begin
               penable_d = 1'b1;
               state_d   = ACCESS;
            end
         end
         ACCESS: begin
            if (apb_clk_en) begin
               if (bus.pready || tout_hit) begin
                  // A hung slave reports an error with no data.
                  rsp_rdata_d = (bus.pready && !pwrite_q) ? bus.prdata : '0;
                  rsp_err_d   = bus.pready ? bus.pslverr : 1'b1;
                  psel_d      = 1'b0;
                  penable_d   = 1'b0;
                  cnt_d       = '0;
                  state_d     = RESP;
               end else if (cnt_q != CNT_MAX) begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         RESP: begin
            if (bus.rsp_rdy) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.req_rdy   = (state_q == IDLE);
   assign bus.rsp_vld   = (state_q == RESP);
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.psel      = psel_q;
   assign bus.penable   = penable_q;
   assign bus.pwrite    = pwrite_q;
   assign bus.paddr     = paddr_q;
   assign bus.pwdata    = pwdata_q;
   assign bus.pstrb     = pstrb_q;

endmodule

// File: tb/tb_aq_apb_mst_bridge.sv
// Bench for aq_apb_mst_bridge: directed vector table, a reset-in-ACCESS
// sequence and randomized transfers checked against a transfer-level model.

module tb_aq_apb_mst_bridge;
   import aq_apb_pkg::*;

   localparam int TOUT = 4;

   typedef struct {
      bit          write;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [31:0] rdata;
      bit          slverr;
      int          waits;
      int          en_mode;
      int          rsp_delay;
      logic [31:0] exp_rdata;
      bit          exp_err;
      logic [3:0]  exp_pstrb;
      int          exp_acc;
   } vec_t;

   logic forever_cpuclk = 1'b0;
   logic cpurst_b;
   logic apb_clk_en;
   bit   en_tog = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 forever_cpuclk = ~forever_cpuclk;

   aq_apb_mst_bridge_if #(.ADDR_W(32)) bus ();

   aq_apb_mst_bridge #(.ADDR_W(32), .TIMEOUT(TOUT)) dut (
      .forever_cpuclk (forever_cpuclk),
      .cpurst_b       (cpurst_b),
      .apb_clk_en     (apb_clk_en),
      .bus            (bus)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] strb, input logic [31:0] rdata, input bit slverr,
                               input int waits, input int en_mode, input int rsp_delay,
                               input logic [31:0] exp_rdata, input bit exp_err,
                               input logic [3:0] exp_pstrb, input int exp_acc);
      vec_t v;
      v.write = wr; v.addr = addr; v.wdata = wdata; v.strb = strb; v.rdata = rdata;
      v.slverr = slverr; v.waits = waits; v.en_mode = en_mode; v.rsp_delay = rsp_delay;
      v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_pstrb = exp_pstrb; v.exp_acc = exp_acc;
      return v;
   endfunction

   // Transfer-level reference: a slave that stalls for 'waits' strobes either
   // completes on the next strobe or is cut off after TOUT strobes in ACCESS.
   function automatic vec_t model(input vec_t v);
      vec_t r = v;
      bit   timed = (TOUT != 0) && (v.waits >= TOUT);
      r.exp_acc   = timed ? TOUT : v.waits + 1;
      r.exp_err   = timed ? 1'b1 : v.slverr;
      r.exp_rdata = (timed || v.write) ? 32'h0 : v.rdata;
      r.exp_pstrb = v.write ? v.strb : 4'h0;
      return r;
   endfunction

   task automatic drive_en(input int mode);
      case (mode)
         0: begin en_tog = ~en_tog; apb_clk_en = en_tog; end
         1: apb_clk_en = 1'b1;
         default: apb_clk_en = 1'($urandom_range(0, 1));
      endcase
   endtask

   task automatic run_xfer(input vec_t v, input string tag);
      int   t_acc = -1, t_psel = -1, t_pen = -1, t_vld = -1, acc = 0, vcyc = 0;
      bit   took = 0, done = 0, stab_bad = 0, ovl_bad = 0, pre_acc, pre_take, pre_done;
      bit   idle_at_rsp = 0;
      logic [31:0] got_rd = '0;
      logic        got_err = 1'b0;
      logic [3:0]  got_strb = '0;
      logic [3:0]  exp_strb = v.write ? v.strb : 4'h0;

      bus.req_vld = 1'b1; bus.req_write = v.write; bus.req_addr = v.addr;
      bus.req_wdata = v.wdata; bus.req_strb = v.strb;
      for (int cyc = 0; cyc < 400 && !done; cyc++) begin
         drive_en(v.en_mode);
         if (bus.psel && bus.penable && apb_clk_en && acc >= v.waits) begin
            bus.pready = 1'b1; bus.prdata = v.rdata; bus.pslverr = v.slverr;
         end else begin
            bus.pready  = (bus.psel && bus.penable && apb_clk_en) ? 1'b0 : 1'($urandom_range(0, 1));
            bus.prdata  = $urandom;
            bus.pslverr = 1'($urandom_range(0, 1));
         end
         if (bus.rsp_vld) bus.rsp_rdy = (vcyc >= v.rsp_delay);
         else             bus.rsp_rdy = 1'($urandom_range(0, 1));
         pre_acc  = apb_clk_en && bus.psel && bus.penable;
         pre_take = bus.req_vld && bus.req_rdy;
         pre_done = bus.rsp_vld && bus.rsp_rdy;
         @(posedge forever_cpuclk); #1;
         if (pre_acc) acc++;
         if (pre_take) begin
            if (took) ovl_bad = 1;
            took = 1; t_acc = cyc;
            bus.req_vld = 1'($urandom_range(0, 1)); bus.req_write = 1'($urandom_range(0, 1));
            bus.req_addr = $urandom; bus.req_wdata = $urandom; bus.req_strb = 4'($urandom);
         end
         if (pre_done) done = 1;
         if (bus.psel && t_psel < 0) t_psel = cyc;
         if (bus.penable && t_pen < 0) t_pen = cyc;
         if (bus.rsp_vld) begin
            if (t_vld < 0) begin
               t_vld = cyc; got_rd = bus.rsp_rdata; got_err = bus.rsp_err; got_strb = bus.pstrb;
               idle_at_rsp = !bus.psel && !bus.penable;
            end else if (bus.rsp_rdata !== got_rd || bus.rsp_err !== got_err) begin
               stab_bad = 1;
            end
            vcyc++;
            if (bus.req_rdy) ovl_bad = 1;
         end
         if (bus.psel && (bus.paddr !== v.addr || bus.pwdata !== v.wdata ||
                          bus.pstrb !== exp_strb || bus.pwrite !== v.write)) stab_bad = 1;
      end
      bus.req_vld = 1'b0;
      bus.rsp_rdy = 1'b0;
      chk({tag, " completed"}, 32'(done), 32'h1);
      if (!done) return;
      chk({tag, " rsp_rdata"}, got_rd, v.exp_rdata);
      chk({tag, " rsp_err"}, 32'(got_err), 32'(v.exp_err));
      chk({tag, " pstrb"}, 32'(got_strb), 32'(v.exp_pstrb));
      chk({tag, " access strobes"}, 32'(acc), 32'(v.exp_acc));
      chk({tag, " bus idle at rsp"}, 32'(idle_at_rsp), 32'h1);
      chk({tag, " stable outputs"}, 32'(stab_bad), 32'h0);
      chk({tag, " single outstanding"}, 32'(ovl_bad), 32'h0);
      chk({tag, " rsp_vld cycles"}, 32'(vcyc), 32'(v.rsp_delay));
      chk({tag, " req_rdy after rsp"}, 32'(bus.req_rdy), 32'h1);
      if (v.en_mode == 0) begin
         chk({tag, " accept to psel <=2"}, 32'((t_psel - t_acc) <= 2 && t_psel > t_acc), 32'h1);
         chk({tag, " psel to penable"}, 32'(t_pen - t_psel), 32'd2);
         chk({tag, " penable to rsp_vld"}, 32'(t_vld - t_pen), 32'(2 * v.exp_acc));
      end else if (v.en_mode == 1) begin
         chk({tag, " accept to psel"}, 32'(t_psel - t_acc), 32'd1);
         chk({tag, " psel to penable"}, 32'(t_pen - t_psel), 32'd1);
         chk({tag, " penable to rsp_vld"}, 32'(t_vld - t_pen), 32'(v.exp_acc));
      end
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, " psel"}, 32'(bus.psel), 32'h0);
      chk({tag, " penable"}, 32'(bus.penable), 32'h0);
      chk({tag, " pwrite"}, 32'(bus.pwrite), 32'h0);
      chk({tag, " paddr"}, bus.paddr, 32'h0);
      chk({tag, " pwdata"}, bus.pwdata, 32'h0);
      chk({tag, " pstrb"}, 32'(bus.pstrb), 32'h0);
      chk({tag, " rsp_vld"}, 32'(bus.rsp_vld), 32'h0);
      chk({tag, " rsp_err"}, 32'(bus.rsp_err), 32'h0);
      chk({tag, " rsp_rdata"}, bus.rsp_rdata, 32'h0);
      chk({tag, " req_rdy"}, 32'(bus.req_rdy), 32'h1);
   endtask

   task automatic reset_in_access();
      bit reached = 0, stray = 0;
      bus.req_vld = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'h0BAD_0000;
      bus.req_wdata = 32'h1; bus.req_strb = 4'hF;
      bus.pready = 1'b0; bus.pslverr = 1'b0; bus.prdata = 32'h0; bus.rsp_rdy = 1'b0;
      for (int i = 0; i < 40 && !reached; i++) begin
         drive_en(0);
         @(posedge forever_cpuclk); #1;
         bus.req_vld = 1'b0;
         reached = bus.psel && bus.penable;
      end
      chk("rst-mid reached access", 32'(reached), 32'h1);
      // Let two stalled strobes advance the timeout counter before reset hits.
      repeat (4) begin drive_en(0); @(posedge forever_cpuclk); #1; end
      cpurst_b = 1'b0;
      @(posedge forever_cpuclk); #1;
      cpurst_b = 1'b1;
      check_reset_vals("rst-mid");
      bus.pready = 1'b1; bus.pslverr = 1'b1; bus.prdata = 32'hFFFF_FFFF; bus.rsp_rdy = 1'b0;
      for (int i = 0; i < 6; i++) begin
         drive_en(0);
         @(posedge forever_cpuclk); #1;
         if (bus.rsp_vld || bus.psel || !bus.req_rdy) stray = 1;
      end
      chk("rst-mid no response", 32'(stray), 32'h0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[9];
      vec_t r;
      vecs[0] = mk(0, 32'h1000_0040, 32'h0, 4'hF, 32'hDEAD_BEEF, 0, 0, 0, 1, 32'hDEAD_BEEF, 0, 4'h0, 1);
      vecs[1] = mk(1, 32'h2000_0010, 32'h1234_5678, 4'b0011, 32'hAAAA_5555, 0, 3, 0, 1, 32'h0, 0, 4'b0011, 4);
      vecs[2] = mk(0, 32'h3000_0004, 32'h0, 4'h0, 32'hCAFE_0001, 1, 0, 0, 5, 32'hCAFE_0001, 1, 4'h0, 1);
      vecs[3] = mk(0, 32'h4000_0000, 32'h0, 4'h0, 32'h1111_1111, 0, 4, 0, 2, 32'h0, 1, 4'h0, 4);
      vecs[4] = mk(1, 32'h4000_0008, 32'h89AB_CDEF, 4'hF, 32'h2222_2222, 0, 9, 2, 1, 32'h0, 1, 4'hF, 4);
      vecs[5] = mk(0, 32'h5000_0000, 32'h0, 4'h0, 32'h0102_0304, 0, 0, 1, 1, 32'h0102_0304, 0, 4'h0, 1);
      vecs[6] = mk(0, 32'h5000_0004, 32'h0, 4'h0, 32'h0506_0708, 0, 0, 1, 1, 32'h0506_0708, 0, 4'h0, 1);
      vecs[7] = mk(1, 32'h6000_0000, 32'h0F0F_0F0F, 4'b1000, 32'h3333_3333, 1, 2, 2, 3, 32'h0, 1, 4'b1000, 3);
      vecs[8] = mk(0, 32'h7000_0000, 32'h0, 4'h0, 32'h8765_4321, 0, 3, 1, 1, 32'h8765_4321, 0, 4'h0, 4);

      cpurst_b = 1'b0; apb_clk_en = 1'b0;
      bus.req_vld = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0; bus.req_strb = '0;
      bus.rsp_rdy = 1'b0; bus.prdata = '0; bus.pready = 1'b0; bus.pslverr = 1'b0;
      repeat (3) @(posedge forever_cpuclk);
      #1;
      check_reset_vals("reset");
      cpurst_b = 1'b1;

      for (int i = 0; i < 9; i++) run_xfer(vecs[i], $sformatf("vec%0d", i));

      reset_in_access();
      run_xfer(vecs[3], "post-rst timeout");

      for (int i = 0; i < 40; i++) begin
         r.write = 1'($urandom_range(0, 1)); r.addr = $urandom; r.wdata = $urandom;
         r.strb = 4'($urandom); r.rdata = $urandom; r.slverr = ($urandom_range(0, 3) == 0);
         r.waits = $urandom_range(0, 6); r.en_mode = $urandom_range(0, 2);
         r.rsp_delay = $urandom_range(1, 3);
         run_xfer(model(r), $sformatf("rnd%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
